// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb sprite: FSM states, sprite geometry,
// sprite ROM layout and screen dimensions.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLIGHT  = 2'd1,
    EXPLODE = 2'd2
  } state_t;

  localparam int SPRITE_W      = 16;
  localparam int SPRITE_H      = 16;
  localparam int SPRITE_W_LOG2 = 4;
  localparam int SPRITE_H_LOG2 = 4;

  localparam logic [17:0] BOMB_BASE = 18'd0;
  localparam logic [17:0] EXPL_BASE = 18'd256;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Clamp a signed coordinate into 0..hi so it can index the visible screen.
  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                             input logic [9:0] hi);
    logic [9:0] r;
    if (v < 12'sd0) begin
      r = '0;
    end else if (v > $signed({2'b00, hi})) begin
      r = hi;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// Pixel hit test and sprite ROM address for one square-ish sprite placed at a
// signed screen position. Pure combinational so it adds no pixel latency.
module sprite_addr_calc #(
  parameter int W_LOG2     = 4,
  parameter int H_LOG2     = 4,
  parameter int FRAME_BITS = 2
) (
  input  logic                    enable,
  input  logic [9:0]              draw_x,
  input  logic [9:0]              draw_y,
  input  logic signed [10:0]      pos_x,
  input  logic signed [10:0]      pos_y,
  input  logic [17:0]             base,
  input  logic [FRAME_BITS-1:0]   frame,
  output logic                    hit,
  output logic [17:0]             addr
);

  localparam logic signed [11:0] W_S = 12'(1 << W_LOG2);
  localparam logic signed [11:0] H_S = 12'(1 << H_LOG2);

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic               in_x;
  logic               in_y;

  // Offset of the current pixel from the sprite corner, bounds test, and a
  // shift-only address so no multiplier is inferred.
  always_comb begin
    dx   = $signed({2'b00, draw_x}) - $signed({pos_x[10], pos_x});
    dy   = $signed({2'b00, draw_y}) - $signed({pos_y[10], pos_y});
    in_x = (dx >= 12'sd0) && (dx < W_S);
    in_y = (dy >= 12'sd0) && (dy < H_S);
    hit  = enable & in_x & in_y;
    addr = '0;
    if (hit) begin
      addr = base
           + (18'(frame) << (W_LOG2 + H_LOG2))
           + (18'(dy[H_LOG2-1:0]) << W_LOG2)
           + 18'(dx[W_LOG2-1:0]);
    end
  end

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb flight and explosion controller. Advances the bomb once per
// video frame under gravity, detects terrain/floor impact, runs the explosion
// animation, and drives the per-pixel sprite lookup for color_mapper.
module bomb_controller
  import bomb_pkg::*;
#(
  parameter int EXPL_FRAMES = 4,
  parameter int FRAME_TICKS = 6,
  parameter int GRAVITY     = 1,
  parameter int VMAX        = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              launch,
  input  logic [9:0]        launch_x,
  input  logic [9:0]        launch_y,
  input  logic signed [5:0] launch_vx,
  input  logic signed [5:0] launch_vy,
  output logic [9:0]        probe_x,
  output logic [9:0]        probe_y,
  input  logic              terrain_hit,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              busy,
  output logic              explode_pulse,
  output logic [9:0]        explode_x,
  output logic [9:0]        explode_y,
  output logic              drawBomb,
  output logic [17:0]       addrBomb
);

  localparam int FRAME_BITS = (EXPL_FRAMES > 1) ? $clog2(EXPL_FRAMES) : 1;
  localparam int TICK_BITS  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [FRAME_BITS-1:0] LAST_FRAME = FRAME_BITS'(EXPL_FRAMES - 1);
  localparam logic [TICK_BITS-1:0]  LAST_TICK  = TICK_BITS'(FRAME_TICKS - 1);

  localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - SPRITE_W);
  localparam logic signed [11:0] Y_FLOOR  = 12'(SCREEN_H - SPRITE_H);
  localparam logic signed [11:0] HALF_W   = 12'(SPRITE_W / 2);
  localparam logic signed [11:0] FULL_H   = 12'(SPRITE_H);
  localparam logic [9:0]         HALF_W10 = 10'(SPRITE_W / 2);
  localparam logic [9:0]         HALF_H10 = 10'(SPRITE_H / 2);
  localparam logic [9:0]         FLOOR_CY = 10'(SCREEN_H - SPRITE_H + SPRITE_H / 2);

  localparam logic signed [6:0]  GRAVITY_S = 7'(GRAVITY);
  localparam logic signed [6:0]  VMAX_S    = 7'(VMAX);

  state_t                  state;
  logic signed [10:0]      x;
  logic signed [10:0]      y;
  logic signed [5:0]       vx;
  logic signed [5:0]       vy;
  logic [FRAME_BITS-1:0]   frame;
  logic [TICK_BITS-1:0]    tick_cnt;

  logic signed [11:0]      nx;
  logic signed [11:0]      ny;
  logic signed [6:0]       vy_inc;
  logic signed [5:0]       vy_next;
  logic signed [11:0]      probe_px;
  logic signed [11:0]      probe_py;

  // Candidate next position, saturated vertical speed and the terrain probe
  // point; computed one bit wider so off-screen moves cannot wrap.
  always_comb begin
    nx       = $signed({x[10], x}) + $signed({{6{vx[5]}}, vx});
    ny       = $signed({y[10], y}) + $signed({{6{vy[5]}}, vy});
    vy_inc   = $signed({vy[5], vy}) + GRAVITY_S;
    vy_next  = (vy_inc > VMAX_S) ? VMAX_S[5:0] : vy_inc[5:0];
    probe_px = $signed({x[10], x}) + HALF_W;
    probe_py = $signed({y[10], y}) + FULL_H;
  end

  assign probe_x = clamp_coord(probe_px, 10'(SCREEN_W - 1));
  assign probe_y = clamp_coord(probe_py, 10'(SCREEN_H - 1));
  assign busy    = (state != IDLE);

  // Bomb life cycle: launch, per-frame motion and impact, explosion timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      vx            <= '0;
      vy            <= '0;
      frame         <= '0;
      tick_cnt      <= '0;
      explode_pulse <= 1'b0;
      explode_x     <= '0;
      explode_y     <= '0;
    end else begin
      explode_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            x     <= $signed({1'b0, launch_x});
            y     <= $signed({1'b0, launch_y});
            vx    <= launch_vx;
            vy    <= launch_vy;
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (frame_tick) begin
            if (terrain_hit) begin
              state         <= EXPLODE;
              explode_pulse <= 1'b1;
              explode_x     <= x[9:0] + HALF_W10;
              explode_y     <= y[9:0] + HALF_H10;
              frame         <= '0;
              tick_cnt      <= '0;
            end else begin
              vy <= vy_next;
              if ((nx < 12'sd0) || (nx > X_MAX)) begin
                state <= IDLE;
              end else if (ny >= Y_FLOOR) begin
                x             <= nx[10:0];
                y             <= Y_FLOOR[10:0];
                state         <= EXPLODE;
                explode_pulse <= 1'b1;
                explode_x     <= nx[9:0] + HALF_W10;
                explode_y     <= FLOOR_CY;
                frame         <= '0;
                tick_cnt      <= '0;
              end else begin
                x <= nx[10:0];
                y <= ny[10:0];
              end
            end
          end
        end
        EXPLODE: begin
          if (frame_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (frame == LAST_FRAME) begin
                frame <= '0;
                state <= IDLE;
              end else begin
                frame <= frame + FRAME_BITS'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                  in_explode;
  logic [17:0]           sprite_base;
  logic [FRAME_BITS-1:0] sprite_frame;

  assign in_explode   = (state == EXPLODE);
  assign sprite_base  = in_explode ? EXPL_BASE : BOMB_BASE;
  assign sprite_frame = in_explode ? frame : '0;

  sprite_addr_calc #(
    .W_LOG2     (SPRITE_W_LOG2),
    .H_LOG2     (SPRITE_H_LOG2),
    .FRAME_BITS (FRAME_BITS)
  ) u_sprite_addr (
    .enable (busy),
    .draw_x (DrawX),
    .draw_y (DrawY),
    .pos_x  (x),
    .pos_y  (y),
    .base   (sprite_base),
    .frame  (sprite_frame),
    .hit    (drawBomb),
    .addr   (addrBomb)
  );

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: directed scenarios from the bomb's
// life cycle plus randomized flights, all checked against a behavioural model.
module tb_bomb_controller;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              frame_tick;
  logic              launch;
  logic [9:0]        launch_x;
  logic [9:0]        launch_y;
  logic signed [5:0] launch_vx;
  logic signed [5:0] launch_vy;
  logic [9:0]        probe_x;
  logic [9:0]        probe_y;
  logic              terrain_hit;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              busy;
  logic              explode_pulse;
  logic [9:0]        explode_x;
  logic [9:0]        explode_y;
  logic              drawBomb;
  logic [17:0]       addrBomb;

  bomb_controller dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .launch        (launch),
    .launch_x      (launch_x),
    .launch_y      (launch_y),
    .launch_vx     (launch_vx),
    .launch_vy     (launch_vy),
    .probe_x       (probe_x),
    .probe_y       (probe_y),
    .terrain_hit   (terrain_hit),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .busy          (busy),
    .explode_pulse (explode_pulse),
    .explode_x     (explode_x),
    .explode_y     (explode_y),
    .drawBomb      (drawBomb),
    .addrBomb      (addrBomb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase 0 idle, 1 flying, 2 exploding; boom counts ticks
  // spent exploding, the animation frame is boom / 6 and it ends at 24.
  int m_phase, m_x, m_y, m_vx, m_vy, m_boom, m_ex, m_ey;
  bit m_pulse;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0;
    m_boom = 0; m_ex = 0; m_ey = 0; m_pulse = 0;
  endfunction

  function automatic void model_boom(int cx, int cy);
    m_phase = 2; m_boom = 0; m_pulse = 1;
    m_ex = cx & 1023; m_ey = cy & 1023;
  endfunction

  function automatic void model_tick(bit th);
    int nx, ny;
    if (m_phase == 1) begin
      if (th) begin
        model_boom(m_x + 8, m_y + 8);
      end else begin
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        m_vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
        if (nx < 0 || nx > 640 - 16) m_phase = 0;
        else if (ny >= 480 - 16) begin
          m_x = nx; m_y = 480 - 16;
          model_boom(m_x + 8, m_y + 8);
        end else begin
          m_x = nx; m_y = ny;
        end
      end
    end else if (m_phase == 2) begin
      m_boom++;
      if (m_boom == 4 * 6) m_phase = 0;
    end
  endfunction

  function automatic void model_draw(int px, int py, output bit hit, output int addr);
    int dx, dy;
    dx = px - m_x; dy = py - m_y;
    hit = (m_phase != 0) && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
    addr = 0;
    if (hit) addr = ((m_phase == 2) ? 256 + (m_boom / 6) * 256 : 0) + dy * 16 + dx;
  endfunction

  // One clock of stimulus: inputs applied at a falling edge, model advanced,
  // and the task returns at the next falling edge with pulses cleared.
  task automatic step(input bit l, input bit t, input bit th);
    launch = l; frame_tick = t; terrain_hit = th;
    m_pulse = 0;
    if (l && m_phase == 0) begin
      m_phase = 1; m_x = int'(launch_x); m_y = int'(launch_y);
      m_vx = int'(launch_vx); m_vy = int'(launch_vy);
    end else if (t) begin
      model_tick(th);
    end
    @(negedge clk);
    launch = 1'b0; frame_tick = 1'b0; terrain_hit = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; launch = 0; frame_tick = 0; terrain_hit = 0;
    launch_x = 0; launch_y = 0; launch_vx = 0; launch_vy = 0;
    DrawX = 0; DrawY = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_launch(int lx, int ly, int lvx, int lvy);
    launch_x = 10'(lx); launch_y = 10'(ly);
    launch_vx = 6'(lvx); launch_vy = 6'(lvy);
  endtask

  task automatic test_reset;
    do_reset();
    DrawX = 0; DrawY = 0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    total++; if (drawBomb !== 1'b0 || addrBomb !== 18'd0) begin bad++; $display("[TB] FAIL reset_draw: got %0b/%0d want 0/0", drawBomb, addrBomb); end
    total++; if (explode_pulse !== 1'b0 || explode_x !== 10'd0 || explode_y !== 10'd0) begin bad++; $display("[TB] FAIL reset_explode: got %0b (%0d,%0d) want 0 (0,0)", explode_pulse, explode_x, explode_y); end
    total++; if (probe_x !== 10'd8 || probe_y !== 10'd16) begin bad++; $display("[TB] FAIL reset_probe: got (%0d,%0d) want (8,16)", probe_x, probe_y); end
  endtask

  task automatic test_flight_motion;
    bit eh; int ea;
    do_reset();
    set_launch(100, 50, 2, 0);
    step(1, 0, 0);
    DrawX = 110; DrawY = 60; #1; model_draw(110, 60, eh, ea);
    total++; if (drawBomb !== eh || addrBomb !== 18'(ea)) begin bad++; $display("[TB] FAIL draw_inside: got %0b/%0d want %0b/%0d", drawBomb, addrBomb, eh, ea); end
    DrawX = 116; #1; model_draw(116, 60, eh, ea);
    total++; if (drawBomb !== eh || addrBomb !== 18'(ea)) begin bad++; $display("[TB] FAIL draw_edge: got %0b/%0d want %0b/%0d", drawBomb, addrBomb, eh, ea); end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      total++; if (probe_x !== 10'(m_x + 8) || probe_y !== 10'(m_y + 16) || busy !== 1'b1) begin bad++; $display("[TB] FAIL flight_tick%0d: got (%0d,%0d) busy=%0b want (%0d,%0d) busy=1", i, probe_x, probe_y, busy, m_x + 8, m_y + 16); end
    end
  endtask

  task automatic test_floor;
    bit eh; int ea;
    do_reset();
    set_launch(300, 460, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0);
      total++; if (probe_y !== 10'(clampi(m_y + 16, 0, 479)) || explode_pulse !== m_pulse) begin bad++; $display("[TB] FAIL floor_tick%0d: got y=%0d pulse=%0b want y=%0d pulse=%0b", i, probe_y, explode_pulse, clampi(m_y + 16, 0, 479), m_pulse); end
    end
    total++; if (explode_x !== 10'(m_ex) || explode_y !== 10'(m_ey)) begin bad++; $display("[TB] FAIL floor_crater: got (%0d,%0d) want (%0d,%0d)", explode_x, explode_y, m_ex, m_ey); end
    step(0, 0, 0);
    total++; if (explode_pulse !== 1'b0) begin bad++; $display("[TB] FAIL floor_pulse_width: got %0b want 0", explode_pulse); end
    repeat (12) step(0, 1, 0);
    DrawX = 300; DrawY = 464; #1; model_draw(300, 464, eh, ea);
    total++; if (drawBomb !== eh || addrBomb !== 18'(ea)) begin bad++; $display("[TB] FAIL floor_frame2_addr: got %0b/%0d want %0b/%0d", drawBomb, addrBomb, eh, ea); end
    repeat (11) step(0, 1, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL floor_busy_23: got %0b want 1", busy); end
    step(0, 1, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL floor_busy_24: got %0b want 0", busy); end
  endtask

  task automatic test_terrain_hit;
    bit eh; int ea;
    do_reset();
    set_launch(200, 100, -3, -4);
    step(1, 0, 0);
    repeat (2) step(0, 1, 0);
    step(0, 1, 1);
    total++; if (probe_x !== 10'(m_x + 8) || probe_y !== 10'(m_y + 16) || explode_pulse !== 1'b1) begin bad++; $display("[TB] FAIL hit_entry: got (%0d,%0d) pulse=%0b want (%0d,%0d) pulse=1", probe_x, probe_y, explode_pulse, m_x + 8, m_y + 16); end
    total++; if (explode_x !== 10'(m_ex) || explode_y !== 10'(m_ey)) begin bad++; $display("[TB] FAIL hit_crater: got (%0d,%0d) want (%0d,%0d)", explode_x, explode_y, m_ex, m_ey); end
    set_launch(10, 10, 1, 1);
    step(1, 0, 0);
    total++; if (explode_pulse !== 1'b0 || busy !== 1'b1 || probe_x !== 10'(m_x + 8)) begin bad++; $display("[TB] FAIL hit_launch_ignored: got pulse=%0b busy=%0b px=%0d want 0/1/%0d", explode_pulse, busy, probe_x, m_x + 8); end
    DrawX = 10'(m_x + 5); DrawY = 10'(m_y + 3); #1; model_draw(m_x + 5, m_y + 3, eh, ea);
    total++; if (drawBomb !== eh || addrBomb !== 18'(ea)) begin bad++; $display("[TB] FAIL hit_expl_addr: got %0b/%0d want %0b/%0d", drawBomb, addrBomb, eh, ea); end
  endtask

  task automatic test_lost;
    int fails;
    do_reset();
    set_launch(620, 200, 5, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    total++; if (busy !== 1'b0 || explode_pulse !== 1'b0) begin bad++; $display("[TB] FAIL lost_state: got busy=%0b pulse=%0b want 0/0", busy, explode_pulse); end
    fails = 0;
    for (int i = 0; i < 30; i++) begin
      DrawX = 10'($urandom_range(600, 639)); DrawY = 10'($urandom_range(195, 220)); #1;
      if (drawBomb !== 1'b0 || addrBomb !== 18'd0) fails++;
    end
    total++; if (fails != 0) begin bad++; $display("[TB] FAIL lost_draw: got %0d drawn pixels want 0", fails); end
    step(0, 0, 0);
    total++; if (explode_pulse !== 1'b0) begin bad++; $display("[TB] FAIL lost_pulse: got %0b want 0", explode_pulse); end
  endtask

  task automatic test_launch_tick_collision;
    do_reset();
    set_launch(40, 300, 3, -2);
    step(1, 1, 0);
    total++; if (probe_x !== 10'd48 || probe_y !== 10'd316) begin bad++; $display("[TB] FAIL collide_no_motion: got (%0d,%0d) want (48,316)", probe_x, probe_y); end
    step(0, 1, 0);
    total++; if (probe_x !== 10'(m_x + 8) || probe_y !== 10'(m_y + 16)) begin bad++; $display("[TB] FAIL collide_next_tick: got (%0d,%0d) want (%0d,%0d)", probe_x, probe_y, m_x + 8, m_y + 16); end
  endtask

  task automatic test_reset_mid_explode;
    bit eh; int ea;
    do_reset();
    set_launch(150, 120, 1, 1);
    step(1, 0, 0);
    step(0, 1, 1);
    repeat (7) step(0, 1, 0);
    DrawX = 10'(m_x + 2); DrawY = 10'(m_y + 2); #1; model_draw(m_x + 2, m_y + 2, eh, ea);
    total++; if (drawBomb !== eh || addrBomb !== 18'(ea)) begin bad++; $display("[TB] FAIL midexp_frame1: got %0b/%0d want %0b/%0d", drawBomb, addrBomb, eh, ea); end
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (busy !== 1'b0 || drawBomb !== 1'b0 || addrBomb !== 18'd0 || explode_pulse !== 1'b0 || explode_x !== 10'd0 || explode_y !== 10'd0) begin bad++; $display("[TB] FAIL midexp_async_reset: got busy=%0b draw=%0b addr=%0d pulse=%0b ex=(%0d,%0d) want all 0", busy, drawBomb, addrBomb, explode_pulse, explode_x, explode_y); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_launch(100, 50, 2, 0);
    step(1, 0, 0);
    DrawX = 110; DrawY = 60; #1;
    total++; if (drawBomb !== 1'b1 || addrBomb !== 18'd170 || probe_x !== 10'd108 || probe_y !== 10'd66) begin bad++; $display("[TB] FAIL midexp_relaunch: got %0b/%0d (%0d,%0d) want 1/170 (108,66)", drawBomb, addrBomb, probe_x, probe_y); end
  endtask

  task automatic test_random_flights;
    bit l, t, th, eh; int ea, px, py;
    for (int f = 0; f < 6; f++) begin
      do_reset();
      set_launch($urandom_range(0, 700), $urandom_range(0, 500), int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
      step(1, 0, 0);
      for (int s = 0; s < 80; s++) begin
        l  = ($urandom_range(0, 9) == 0);
        t  = ($urandom_range(0, 2) != 0);
        th = t && ($urandom_range(0, 24) == 0);
        if (l) set_launch($urandom_range(0, 620), $urandom_range(0, 460), int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
        step(l, t, th);
        px = clampi(m_x + int'($urandom_range(0, 21)) - 3, 0, 1023);
        py = clampi(m_y + int'($urandom_range(0, 21)) - 3, 0, 1023);
        DrawX = 10'(px); DrawY = 10'(py); #1;
        model_draw(px, py, eh, ea);
        total++; if (busy !== (m_phase != 0) || explode_pulse !== m_pulse) begin bad++; $display("[TB] FAIL rnd_state f%0d s%0d: got busy=%0b pulse=%0b want %0b/%0b", f, s, busy, explode_pulse, m_phase != 0, m_pulse); end
        total++; if (probe_x !== 10'(clampi(m_x + 8, 0, 639)) || probe_y !== 10'(clampi(m_y + 16, 0, 479))) begin bad++; $display("[TB] FAIL rnd_probe f%0d s%0d: got (%0d,%0d) want (%0d,%0d)", f, s, probe_x, probe_y, clampi(m_x + 8, 0, 639), clampi(m_y + 16, 0, 479)); end
        total++; if (explode_x !== 10'(m_ex) || explode_y !== 10'(m_ey)) begin bad++; $display("[TB] FAIL rnd_crater f%0d s%0d: got (%0d,%0d) want (%0d,%0d)", f, s, explode_x, explode_y, m_ex, m_ey); end
        total++; if (drawBomb !== eh || addrBomb !== 18'(ea)) begin bad++; $display("[TB] FAIL rnd_draw f%0d s%0d at (%0d,%0d): got %0b/%0d want %0b/%0d", f, s, px, py, drawBomb, addrBomb, eh, ea); end
      end
    end
  endtask

  // Hard time limit so a stuck run still reports and ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence followed by the single summary line.
  initial begin
    reset_n = 1'b0; launch = 0; frame_tick = 0; terrain_hit = 0;
    launch_x = 0; launch_y = 0; launch_vx = 0; launch_vy = 0;
    DrawX = 0; DrawY = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_flight_motion();
    test_floor();
    test_terrain_hit();
    test_lost();
    test_launch_tick_collision();
    test_reset_mid_explode();
    test_random_flights();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
